// File: rtl/core_bus_pkg.sv
// Shared encodings for the 8088 bus unit: FSM states, access kinds and the
// value returned when a memory read is abandoned.
package core_bus_pkg;

  localparam logic [1:0] ST_DECODE = 2'd0;
  localparam logic [1:0] ST_MEM    = 2'd1;
  localparam logic [1:0] ST_PORT   = 2'd2;
  localparam logic [1:0] ST_PULSE  = 2'd3;

  typedef enum logic [1:0] {
    KIND_RD  = 2'd0,
    KIND_WR  = 2'd1,
    KIND_PRD = 2'd2,
    KIND_PWR = 2'd3
  } kind_e;

  localparam logic [7:0] FLOAT_DATA = 8'hFF;

  // Port write wins over port read, which wins over memory write; plain read otherwise.
  function automatic kind_e decode_kind(input logic we, input logic pr, input logic pw);
    kind_e k;
    if (pw)      k = KIND_PWR;
    else if (pr) k = KIND_PRD;
    else if (we) k = KIND_WR;
    else         k = KIND_RD;
    return k;
  endfunction

endpackage

// File: rtl/core_bus_if.sv
// Bus bundle between the 8088 core, the bus unit, external memory and the port bus.
// slave = the bus unit's view; master = the surrounding core/memory/port side.
interface core_bus_if;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic        cpu_pr;
  logic        cpu_pw;
  logic [7:0]  cpu_in;
  logic        cpu_ce;

  logic [19:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic [15:0] port_address;
  logic [7:0]  port_wdata;
  logic        port_rd;
  logic        port_wr;
  logic [7:0]  port_rdata;

  modport slave (
    input  cpu_address, cpu_out, cpu_we, cpu_pr, cpu_pw,
    output cpu_in, cpu_ce,
    output mem_address, mem_wdata, mem_we, mem_req,
    input  mem_ack, mem_rdata,
    output port_address, port_wdata, port_rd, port_wr,
    input  port_rdata
  );

  modport master (
    output cpu_address, cpu_out, cpu_we, cpu_pr, cpu_pw,
    input  cpu_in, cpu_ce,
    input  mem_address, mem_wdata, mem_we, mem_req,
    output mem_ack, mem_rdata,
    input  port_address, port_wdata, port_rd, port_wr,
    output port_rdata
  );
endinterface

// File: rtl/core_bus.sv
// Bus unit behind the 8088 core: runs one memory or port access per request,
// paces the core with a one-cycle cpu_ce pulse and caches the last byte read.
module core_bus
  import core_bus_pkg::*;
#(
  parameter int PORT_WAIT   = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic      clock,
  input  logic      reset_n,
  core_bus_if.slave bus
);

  localparam int TMO_W  = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int PCNT_W = (PORT_WAIT < 2) ? 1 : $clog2(PORT_WAIT);

  logic [1:0]        state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [19:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]        cpu_in_q, cpu_in_d;

  logic              cache_valid_q, cache_valid_d;
  logic [19:0]       cache_tag_q, cache_tag_d;
  logic [7:0]        cache_data_q, cache_data_d;

  logic [TMO_W-1:0]  tmo_inc;
  logic              cache_hit;

  assign tmo_inc   = tmo_q + 1'b1;
  assign cache_hit = cache_valid_q && (cache_tag_q == bus.cpu_address);

  always_comb begin
    state_d       = state_q;
    kind_d        = kind_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    tmo_d         = tmo_q;
    pcnt_d        = pcnt_q;
    cpu_in_d      = cpu_in_q;
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;

    case (state_q)
      ST_DECODE: begin
        kind_d  = decode_kind(bus.cpu_we, bus.cpu_pr, bus.cpu_pw);
        addr_d  = bus.cpu_address;
        wdata_d = bus.cpu_out;
        tmo_d   = '0;
        pcnt_d  = '0;
        if (kind_d == KIND_RD && cache_hit) begin
          cpu_in_d = cache_data_q;
          state_d  = ST_PULSE;
        end else if (kind_d == KIND_PRD || kind_d == KIND_PWR) begin
          state_d = ST_PORT;
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_MEM: begin
        if (bus.mem_ack) begin
          state_d = ST_PULSE;
          tmo_d   = '0;
          if (kind_q == KIND_RD) begin
            cpu_in_d      = bus.mem_rdata;
            cache_valid_d = 1'b1;
            cache_tag_d   = addr_q;
            cache_data_d  = bus.mem_rdata;
          end else if (cache_tag_q == addr_q) begin
            cache_data_d = wdata_q;
          end
        end else if (tmo_inc == TMO_W'(MEM_TIMEOUT)) begin
          // Abandoned access: reads see a floating bus, writes vanish, cache untouched.
          state_d = ST_PULSE;
          tmo_d   = '0;
          if (kind_q == KIND_RD) cpu_in_d = FLOAT_DATA;
        end else begin
          tmo_d = tmo_inc;
        end
      end

      ST_PORT: begin
        if (pcnt_q == PCNT_W'(PORT_WAIT - 1)) begin
          state_d = ST_PULSE;
          if (kind_q == KIND_PRD) cpu_in_d = bus.port_rdata;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end

      ST_PULSE: state_d = ST_DECODE;

      default: state_d = ST_DECODE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_DECODE;
      kind_q        <= KIND_RD;
      addr_q        <= '0;
      wdata_q       <= '0;
      tmo_q         <= '0;
      pcnt_q        <= '0;
      cpu_in_q      <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      tmo_q         <= tmo_d;
      pcnt_q        <= pcnt_d;
      cpu_in_q      <= cpu_in_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  // Tag and data are only meaningful while cache_valid_q is set.
  always_ff @(posedge clock) begin
    cache_tag_q  <= cache_tag_d;
    cache_data_q <= cache_data_d;
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign bus.cpu_in       = cpu_in_q;
  assign bus.cpu_ce       = (state_q == ST_PULSE);
  assign bus.mem_address  = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_req      = (state_q == ST_MEM);
  assign bus.mem_we       = (state_q == ST_MEM) && (kind_q == KIND_WR);
  assign bus.port_address = addr_q[15:0];
  assign bus.port_wdata   = wdata_q;
  assign bus.port_rd      = (state_q == ST_PORT) && (kind_q == KIND_PRD);
  assign bus.port_wr      = (state_q == ST_PORT) && (kind_q == KIND_PWR);

endmodule

// File: tb/tb_core_bus.sv
// Self-checking bench for core_bus: transaction-level model of the core, memory
// and port bus, checked cycle by cycle, with directed literal scenarios.
module tb_core_bus;

  localparam int PW  = 2;
  localparam int TMO = 255;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  core_bus_if bus ();

  core_bus #(.PORT_WAIT(PW), .MEM_TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the single cached byte and the byte last handed to the core.
  bit          m_valid  = 1'b0;
  logic [19:0] m_tag    = '0;
  logic [7:0]  m_data   = '0;
  logic [7:0]  m_cpu_in = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cpu_in"},   bus.cpu_in, 8'h00);
    check({tag, "_cpu_ce"},   bus.cpu_ce, 1'b0);
    check({tag, "_mem_req"},  bus.mem_req, 1'b0);
    check({tag, "_mem_we"},   bus.mem_we, 1'b0);
    check({tag, "_mem_addr"}, bus.mem_address, 20'h0);
    check({tag, "_mem_wd"},   bus.mem_wdata, 8'h00);
    check({tag, "_port_rd"},  bus.port_rd, 1'b0);
    check({tag, "_port_wr"},  bus.port_wr, 1'b0);
    check({tag, "_port_adr"}, bus.port_address, 16'h0);
    check({tag, "_port_wd"},  bus.port_wdata, 8'h00);
  endtask

  // Entered at the falling edge inside a DECODE cycle; returns at the falling
  // edge of the next DECODE cycle. waits < 0 means memory never acknowledges.
  task automatic run_txn(input bit we, input bit pr, input bit pw,
                         input logic [19:0] addr, input logic [7:0] wd,
                         input int waits, input logic [7:0] rd, input logic [7:0] prd,
                         output int lat, output logic [7:0] din,
                         output int reqs, output int strobes);
    int k, mlen, ce_t, t;
    bit hit, is_mem, acked, exp_req, exp_prd, exp_pwr;
    logic [7:0] exp_in;

    k      = pw ? 3 : pr ? 2 : we ? 1 : 0;
    hit    = (k == 0) && m_valid && (m_tag == addr);
    is_mem = !hit && (k <= 1);
    mlen   = (waits < 0 || waits >= TMO) ? TMO : waits + 1;
    acked  = is_mem && waits >= 0 && waits < TMO;
    ce_t   = hit ? 2 : is_mem ? 2 + mlen : 2 + PW;
    if (hit)          exp_in = m_data;
    else if (k == 0)  exp_in = acked ? rd : 8'hFF;
    else if (k == 2)  exp_in = prd;
    else              exp_in = m_cpu_in;

    bus.cpu_we      = we;
    bus.cpu_pr      = pr;
    bus.cpu_pw      = pw;
    bus.cpu_address = addr;
    bus.cpu_out     = wd;

    lat = 0; reqs = 0; strobes = 0; t = 1;
    forever begin
      if (bus.mem_req === 1'b1) begin
        reqs++;
        if (acked && reqs == waits + 1) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = rd;
        end else begin
          bus.mem_ack = 1'b0; bus.mem_rdata = 8'($urandom);
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (bus.port_rd === 1'b1 || bus.port_wr === 1'b1) begin
        strobes++;
        bus.port_rdata = (strobes == PW) ? prd : 8'($urandom);
      end

      exp_req = is_mem && t >= 2 && t <= 1 + mlen;
      exp_prd = (k == 2) && t >= 2 && t <= 1 + PW;
      exp_pwr = (k == 3) && t >= 2 && t <= 1 + PW;
      check("mem_req", bus.mem_req, exp_req);
      check("port_rd", bus.port_rd, exp_prd);
      check("port_wr", bus.port_wr, exp_pwr);
      check("cpu_ce",  bus.cpu_ce, t == ce_t);
      check("cpu_in",  bus.cpu_in, (t >= ce_t) ? exp_in : m_cpu_in);
      if (exp_req) begin
        check("mem_address", bus.mem_address, addr);
        check("mem_we", bus.mem_we, k == 1);
        if (k == 1) check("mem_wdata", bus.mem_wdata, wd);
      end
      if (exp_prd || exp_pwr) begin
        check("port_address", bus.port_address, addr[15:0]);
        if (k == 3) check("port_wdata", bus.port_wdata, wd);
      end

      if (bus.cpu_ce === 1'b1 && lat == 0) lat = t;
      if (t >= ce_t && (lat != 0 || t >= ce_t + 4)) break;
      @(posedge clock); @(negedge clock); t++;
    end

    if (lat == 0) begin
      n_tests++; n_fail++;
      $display("FAIL ce_bound: no cpu_ce within %0d cycles, expected at cycle %0d", t, ce_t);
    end
    din = bus.cpu_in;

    m_cpu_in = exp_in;
    if (k == 0 && acked) begin
      m_valid = 1'b1; m_tag = addr; m_data = rd;
    end
    if (k == 1 && acked && m_valid && m_tag == addr) m_data = wd;

    @(posedge clock); @(negedge clock);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, reqs, strobes;
    logic [7:0] din;
    logic [19:0] addr_tbl [6];
    addr_tbl = '{20'h12345, 20'h12346, 20'h00400, 20'hFFFFF, 20'h00060, 20'h80060};

    bus.cpu_address = 20'h0; bus.cpu_out = 8'h0;
    bus.cpu_we = 1'b0; bus.cpu_pr = 1'b0; bus.cpu_pw = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h99; bus.port_rdata = 8'h00;

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    run_txn(0, 0, 0, 20'h12345, 8'h00, 0, 8'hA5, 8'h00, lat, din, reqs, strobes);
    check("rd_miss_lat", lat, 3); check("rd_miss_data", din, 8'hA5); check("rd_miss_reqs", reqs, 1);

    run_txn(0, 0, 0, 20'h12345, 8'h00, 0, 8'h11, 8'h00, lat, din, reqs, strobes);
    check("rd_hit_lat", lat, 2); check("rd_hit_data", din, 8'hA5); check("rd_hit_reqs", reqs, 0);

    run_txn(1, 0, 0, 20'h12345, 8'h3C, 2, 8'h00, 8'h00, lat, din, reqs, strobes);
    check("wr_lat", lat, 5); check("wr_reqs", reqs, 3); check("wr_keeps_cpu_in", din, 8'hA5);

    run_txn(0, 0, 0, 20'h12345, 8'h00, 0, 8'h22, 8'h00, lat, din, reqs, strobes);
    check("rd_after_wr_lat", lat, 2); check("rd_after_wr_data", din, 8'h3C);

    run_txn(0, 1, 0, 20'h00060, 8'h00, 0, 8'h00, 8'h7E, lat, din, reqs, strobes);
    check("prd_lat", lat, 4); check("prd_data", din, 8'h7E);
    check("prd_strobes", strobes, 2); check("prd_reqs", reqs, 0);

    run_txn(0, 0, 0, 20'h12345, 8'h00, 0, 8'h33, 8'h00, lat, din, reqs, strobes);
    check("cache_after_port", din, 8'h3C); check("cache_after_port_lat", lat, 2);

    run_txn(0, 0, 0, 20'h00400, 8'h00, -1, 8'h00, 8'h00, lat, din, reqs, strobes);
    check("tmo_lat", lat, 257); check("tmo_data", din, 8'hFF); check("tmo_reqs", reqs, 255);

    run_txn(0, 0, 0, 20'h00400, 8'h00, 0, 8'h5B, 8'h00, lat, din, reqs, strobes);
    check("after_tmo_miss_reqs", reqs, 1); check("after_tmo_lat", lat, 3);
    check("after_tmo_data", din, 8'h5B);

    run_txn(1, 0, 1, 20'h00070, 8'hC3, 0, 8'h00, 8'h00, lat, din, reqs, strobes);
    check("pw_we_strobes", strobes, 2); check("pw_we_reqs", reqs, 0); check("pw_we_lat", lat, 4);

    for (int i = 0; i < 200; i++) begin
      bit r_we, r_pr, r_pw;
      int r_w;
      r_we = ($urandom_range(0, 3) == 0);
      r_pr = ($urandom_range(0, 5) == 0);
      r_pw = ($urandom_range(0, 7) == 0);
      r_w  = ($urandom_range(0, 39) == 0) ? -1 : int'($urandom_range(0, 4));
      run_txn(r_we, r_pr, r_pw, addr_tbl[$urandom_range(0, 5)], 8'($urandom), r_w,
              8'($urandom), 8'($urandom), lat, din, reqs, strobes);
    end

    // Fill the cache, then reset in the middle of a memory access.
    run_txn(0, 0, 0, 20'h12345, 8'h00, 1, 8'h6D, 8'h00, lat, din, reqs, strobes);
    bus.cpu_address = 20'h54321; bus.cpu_we = 1'b0; bus.cpu_pr = 1'b0; bus.cpu_pw = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (2) begin @(posedge clock); @(negedge clock); end
    check("midmem_req_before", bus.mem_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midmem_reset");
    m_valid = 1'b0; m_cpu_in = 8'h00;
    bus.mem_ack = 1'b1;
    @(posedge clock); @(negedge clock);
    reset_n = 1'b1;

    run_txn(0, 0, 0, 20'h12345, 8'h00, 1, 8'h5A, 8'h00, lat, din, reqs, strobes);
    check("post_reset_miss_reqs", reqs, 2); check("post_reset_lat", lat, 4);
    check("post_reset_data", din, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
